// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, forward/inverse S-box tables, SubBytes FSM encoding.
// Latency: n/a (constants and a combinational lookup helper only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_DONE = 2'd2
    } sb_state_e;

    // Tables stored entry 0 first (MSB), so entry n is bits [8n +: 8].
    localparam logic [0:2047] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [AES_BYTE_W-1:0] sbox_lookup(input logic [AES_BYTE_W-1:0] idx,
                                                          input logic inv);
        return inv ? SBOX_INV[AES_BYTE_W*idx +: AES_BYTE_W]
                   : SBOX_FWD[AES_BYTE_W*idx +: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for sub_bytes_seq: input valid/ready + state/mode, output valid/ready + state, busy.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer; in_ready back to the producer.
interface sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [0:AES_STATE_W-1] state_in;
    logic                   inv_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [0:AES_STATE_W-1] state_out;
    logic                   busy;

    // master: the side that feeds states in and drains results
    modport master (
        output in_valid, state_in, inv_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    // slave: the SubBytes engine
    modport slave (
        input  in_valid, state_in, inv_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );

endinterface

// File: rtl/sbox_dual.sv
// Single AES S-box lane, forward or inverse selected by inv. Ports: idx in, inv in, result out.
// Latency: combinational.
// Backpressure: none.
module sbox_dual
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] idx,
    input  logic                  inv,
    output logic [AES_BYTE_W-1:0] result
);

    assign result = sbox_lookup(idx, inv);

endmodule

// File: rtl/sub_bytes_seq.sv
// SubBytes over a 128-bit state using LANES S-box lanes, time-multiplexed over 16/LANES cycles.
// Latency: out_valid rises 16/LANES edges after the accepting edge; result held in DONE.
// Backpressure: out_ready=0 parks the block in DONE with in_ready=0; a new block may enter on the draining edge.
// Ports: clk, rst (sync, active-high); io = sub_bytes_seq_if.slave (in/out handshakes, state_in/out, inv_in, busy).
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic           clk,
    input  logic           rst,
    sub_bytes_seq_if.slave io
);

    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    localparam logic [1:0]    IDLE     = SB_IDLE;
    localparam logic [1:0]    BUSY     = SB_BUSY;
    localparam logic [1:0]    DONE     = SB_DONE;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]             st_q;
    logic [CW-1:0]          cnt_q;
    logic [0:AES_STATE_W-1] work_q;
    logic [0:AES_STATE_W-1] res_q;
    logic                   mode_q;
    logic                   out_valid_q;
    logic                   accept;

    logic [AES_BYTE_W-1:0]  lane_in  [LANES];
    logic [AES_BYTE_W-1:0]  lane_out [LANES];

    // A parked result frees the slot on the same edge it drains.
    assign io.in_ready  = (st_q == IDLE) || ((st_q == DONE) && io.out_ready);
    assign accept       = io.in_valid && io.in_ready;
    assign io.out_valid = out_valid_q;
    assign io.state_out = res_q;
    assign io.busy      = (st_q == BUSY) || (st_q == DONE);

    // Lane i handles byte cnt*LANES+i of the latched state.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = work_q[AES_BYTE_W*(int'(cnt_q)*LANES + i) +: AES_BYTE_W];

        sbox_dual u_sbox (
            .idx    (lane_in[i]),
            .inv    (mode_q),
            .result (lane_out[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            res_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (st_q)
                IDLE: ;
                BUSY: begin
                    for (int i = 0; i < LANES; i++) begin
                        res_q[AES_BYTE_W*(int'(cnt_q)*LANES + i) +: AES_BYTE_W] <= lane_out[i];
                    end
                    if (cnt_q == CNT_LAST) begin
                        st_q        <= DONE;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        st_q        <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: st_q <= IDLE;
            endcase

            // Accept overrides the DONE->IDLE exit so back-to-back blocks lose no cycle.
            if (accept) begin
                work_q <= io.state_in;
                mode_q <= io.inv_in;
                cnt_q  <= '0;
                st_q   <= BUSY;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

    localparam int NDUT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   sel;
    logic         drv_valid;
    logic         drv_inv;
    logic         drv_out_ready;
    logic [127:0] drv_state;

    logic [NDUT-1:0] ov_all, ir_all, by_all;
    logic [127:0]    so_all [NDUT];

    logic         cur_ov, cur_ir, cur_busy;
    logic [127:0] cur_so;

    assign cur_ov   = ov_all[sel];
    assign cur_ir   = ir_all[sel];
    assign cur_busy = by_all[sel];
    assign cur_so   = so_all[sel];

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int out_cnt = 0;

    // DUT 0 has LANES=4; DUTs 1..4 cover the other legal widths.
    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int L = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : 16;

        sub_bytes_seq_if bus ();

        assign bus.in_valid  = drv_valid && (sel == 3'(k));
        assign bus.state_in  = drv_state;
        assign bus.inv_in    = drv_inv;
        assign bus.out_ready = drv_out_ready;

        assign ov_all[k] = bus.out_valid;
        assign ir_all[k] = bus.in_ready;
        assign by_all[k] = bus.busy;
        assign so_all[k] = bus.state_out;

        sub_bytes_seq #(.LANES(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .io  (bus)
        );
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (drv_valid && cur_ir)      acc_cnt <= acc_cnt + 1;
            if (cur_ov && drv_out_ready)  out_cnt <= out_cnt + 1;
        end
    end

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = s[127-8*k -: 8];
            r[127-8*k -: 8] = inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Push one block through the selected DUT, check latency/busy/data, then drain it.
    task automatic run_block(input logic [127:0] st, input logic inv, input logic [127:0] exp,
                             input int exp_lat, input int stall, input string tag);
        int w, lat;
        bit busy_ok;
        drv_state     = st;
        drv_inv       = inv;
        drv_valid     = 1'b1;
        drv_out_ready = (stall == 0);
        w = 0;
        #1;
        while (!cur_ir && w < 50) begin
            tick();
            #1;
            w++;
        end
        chk({tag, " accept"}, cur_ir, 1'b1);
        tick();
        drv_valid = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!cur_ov && lat < 40) begin
            if (!cur_busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, busy_ok && cur_busy, 1'b1);
        chk({tag, " data"}, cur_so, exp);
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) tick();
            chk({tag, " stall hold"}, {cur_ov, cur_so}, {1'b1, exp});
            drv_out_ready = 1'b1;
        end
        tick();
        chk({tag, " drain"}, cur_ov, 1'b0);
    endtask

    typedef struct {
        logic [127:0] st;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk_x, blk_y, res_x;
        bit           quiet;
        int           a0, o0, lat;
        int           lanes_of [NDUT];

        lanes_of = '{4, 1, 2, 8, 16};

        tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        tbl[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        tbl[2] = '{128'h0, 1'b1, {16{8'h52}}};
        tbl[3] = '{128'h0, 1'b0, {16{8'h63}}};
        tbl[4] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
        tbl[5] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76};
        tbl[6] = '{{16{8'h63}}, 1'b1, 128'h0};

        for (int x = 0; x < 256; x++) begin
            logic [7:0] f;
            f = ref_fwd(8'(x));
            fwd_tab[x] = f;
            inv_tab[f] = 8'(x);
        end

        rst = 1'b1; sel = 3'd0; drv_valid = 1'b0; drv_inv = 1'b0;
        drv_out_ready = 1'b1; drv_state = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset out_valid", ov_all, '0);
        chk("reset busy", by_all, '0);
        chk("reset in_ready", ir_all, {NDUT{1'b1}});
        chk("reset state_out", so_all[0], '0);

        // Directed vectors on LANES=4.
        for (int i = 0; i < 7; i++) begin
            run_block(tbl[i].st, tbl[i].inv, tbl[i].exp, 4, 0, $sformatf("vec%0d", i));
        end

        // Backpressure: park the result, poke in_valid, then drain and refill on one edge.
        blk_x = tbl[0].st;
        blk_y = tbl[1].st;
        drv_out_ready = 1'b0;
        drv_state = blk_x; drv_inv = 1'b0; drv_valid = 1'b1;
        #1;
        chk("bp accept", cur_ir, 1'b1);
        tick();
        drv_valid = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 40) begin tick(); lat++; end
        chk("bp latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            drv_valid = i[0];
            drv_state = {$urandom, $urandom, $urandom, $urandom};
            drv_inv   = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("bp hold ov c%0d", i), cur_ov, 1'b1);
            chk($sformatf("bp hold data c%0d", i), cur_so, tbl[0].exp);
            chk($sformatf("bp in_ready c%0d", i), cur_ir, 1'b0);
            tick();
        end
        drv_valid = 1'b1; drv_state = blk_y; drv_inv = 1'b1; drv_out_ready = 1'b1;
        #1;
        chk("bp refill in_ready", cur_ir, 1'b1);
        tick();
        drv_valid = 1'b0;
        chk("bp refill ov drop", cur_ov, 1'b0);
        chk("bp refill busy", cur_busy, 1'b1);
        lat = 0;
        while (!cur_ov && lat < 40) begin tick(); lat++; end
        chk("bp refill latency", lat, 4);
        chk("bp refill data", cur_so, blk_x);
        tick();

        // Reset while the counter sits at 1.
        drv_state = blk_x; drv_inv = 1'b0; drv_valid = 1'b1;
        #1;
        chk("rst accept", cur_ir, 1'b1);
        tick();
        drv_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst mid ov/busy/ready", {cur_ov, cur_busy, cur_ir}, 3'b001);
        chk("rst mid state_out", cur_so, '0);
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cur_ov) quiet = 1'b0;
        end
        chk("rst no stale output", quiet, 1'b1);
        res_x = sub_state(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
        run_block(128'h3243f6a8885a308d313198a2e0370734, 1'b0, res_x, 4, 0, "rst fresh");

        // Parameter sweep on the other lane counts.
        for (int k = 1; k < NDUT; k++) begin
            sel = 3'(k);
            a0 = acc_cnt;
            o0 = out_cnt;
            for (int n = 0; n < 200; n++) begin
                logic [127:0] st;
                logic         inv;
                int           stall;
                st    = {$urandom, $urandom, $urandom, $urandom};
                inv   = 1'($urandom_range(0, 1));
                stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                run_block(st, inv, sub_state(st, inv), 16 / lanes_of[k], stall,
                          $sformatf("sweep L%0d n%0d", lanes_of[k], n));
            end
            tick();
            chk($sformatf("sweep L%0d accepts", lanes_of[k]), acc_cnt - a0, 200);
            chk($sformatf("sweep L%0d outputs", lanes_of[k]), out_cnt - o0, 200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
